// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 receiver: 2-FF sync + glitch filter, 11-bit frame FSM, make/break/E0 decode to held key levels.
// Latency: SCAN_CODE/SCAN_VALID/key outputs update one CLK after the filtered stop-bit falling edge.
// Backpressure: none; the keyboard stream is free-running, and every accepted byte is decoded and pulsed once.
// Optional: define PS2_TIMEOUT_EN to abort a partial frame after TIMEOUT_CYCLES cycles without a PS2_CLK edge.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       ESC,
    output logic       R,
    output logic       S,
    output logic       P,
    output logic       UP,
    output logic       DOWN,
    output logic       LEFT,
    output logic       RIGHT,
    output logic [7:0] SCAN_CODE,
    output logic       SCAN_VALID,
    output logic       FRAME_ERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // The filter counter only has to reach FILTER_LEN-1.
    localparam int              FILT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic              ps2_clk_s1, ps2_clk_s2;
    logic              ps2_dat_s1, ps2_dat_s2;
    logic              ps2_clk_filt;
    logic [FILT_W-1:0] filt_cnt;
    logic              filt_flip;
    logic              fall_edge;

    logic [1:0]        state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic              par_bit;
    logic              stop_edge;
    logic              frame_good;
    logic              frame_ok;
    logic              frame_bad;
    logic              tmo_hit;

    logic              ext_flag;
    logic              brk_flag;

    // Two-flop synchronisers; both lines idle high, so reset to 1 to avoid a fake edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps2_clk_s1 <= 1'b1;
            ps2_clk_s2 <= 1'b1;
            ps2_dat_s1 <= 1'b1;
            ps2_dat_s2 <= 1'b1;
        end else begin
            ps2_clk_s1 <= PS2_CLK;
            ps2_clk_s2 <= ps2_clk_s1;
            ps2_dat_s1 <= PS2_DATA;
            ps2_dat_s2 <= ps2_dat_s1;
        end
    end

    // The filtered level flips on the FILTER_LEN-th consecutive sample that disagrees with it.
    assign filt_flip = (ps2_clk_s2 != ps2_clk_filt) && (filt_cnt == FILT_LAST);
    assign fall_edge = filt_flip && ps2_clk_filt;

    // Glitch filter: count consecutive disagreeing samples, restart on any agreeing one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps2_clk_filt <= 1'b1;
            filt_cnt     <= '0;
        end else if (ps2_clk_s2 == ps2_clk_filt) begin
            filt_cnt     <= '0;
        end else if (filt_flip) begin
            ps2_clk_filt <= ps2_clk_s2;
            filt_cnt     <= '0;
        end else begin
            filt_cnt     <= filt_cnt + 1'b1;
        end
    end

    // Odd parity: data bits plus parity bit must hold an odd number of ones, and stop must be 1.
    assign stop_edge  = fall_edge && (state == ST_STOP);
    assign frame_good = (^{shift_reg, par_bit}) && ps2_dat_s2;
    assign frame_ok   = stop_edge && frame_good;
    assign frame_bad  = stop_edge && !frame_good;

`ifdef PS2_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state != ST_IDLE) && !fall_edge && (tmo_cnt == TMO_LAST);

    // Idle-time counter inside a frame; any clock edge restarts it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
        end else if (fall_edge || (state == ST_IDLE) || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Frame FSM: one step per filtered falling edge; a timeout drops back to IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            par_bit   <= 1'b0;
        end else if (fall_edge) begin
            case (state)
                ST_IDLE: begin
                    if (!ps2_dat_s2) begin
                        state   <= ST_DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_reg <= {ps2_dat_s2, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_bit <= ps2_dat_s2;
                    state   <= ST_STOP;
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= 3'd0;
                end
            endcase
        end else if (tmo_hit) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
        end
    end

    // Byte publish, error pulse and make/break decode into held key levels.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SCAN_CODE  <= 8'h00;
            SCAN_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            ESC        <= 1'b0;
            R          <= 1'b0;
            S          <= 1'b0;
            P          <= 1'b0;
            UP         <= 1'b0;
            DOWN       <= 1'b0;
            LEFT       <= 1'b0;
            RIGHT      <= 1'b0;
        end else begin
            SCAN_VALID <= frame_ok;
            FRAME_ERR  <= frame_bad || tmo_hit;
            if (frame_bad || tmo_hit) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (frame_ok) begin
                SCAN_CODE <= shift_reg;
                case (shift_reg)
                    8'hE0: ext_flag <= 1'b1;
                    8'hF0: brk_flag <= 1'b1;
                    default: begin
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                        // Keypad arrows share codes with the E0 arrows, so ext selects the table.
                        if (!ext_flag) begin
                            case (shift_reg)
                                8'h76:   ESC <= ~brk_flag;
                                8'h2D:   R   <= ~brk_flag;
                                8'h1B:   S   <= ~brk_flag;
                                8'h4D:   P   <= ~brk_flag;
                                default: ;
                            endcase
                        end else begin
                            case (shift_reg)
                                8'h75:   UP    <= ~brk_flag;
                                8'h72:   DOWN  <= ~brk_flag;
                                8'h6B:   LEFT  <= ~brk_flag;
                                8'h74:   RIGHT <= ~brk_flag;
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule
